// File: rtl/mss_updown_timer.sv
// Purpose : min:sec:sub-second up/down timer with run/pause, load, clear, wrap or saturate at terminal.
// Latency : clear/load/step results are visible one cycle after the causing edge; all outputs registered.
// Backpress: none; control inputs are sampled every sclk cycle and act immediately.
//
// Ports:
//   sclk, nrst          clock, asynchronous active-low reset
//   run, dir, wrap_en   count enable, 1 = up / 0 = down, 1 = wrap / 0 = stop at terminal
//   clear, load         single-cycle pulses (clear > load > step > hold)
//   load_val            {min, sec, sub}, each slice clamped to its *_MAX
//   min, sec, sub       current fields; all_time = {min, sec, sub}
//   tick, done, zero    step pulse, landed-on-terminal pulse, all-fields-zero level
// Optional feature (MSS_UPDOWN_TIMER_LAP_EN): lap in, lap_time / lap_valid out.

module mss_updown_timer #(
  parameter int unsigned TICK_DIV = 5_000_000,
  parameter int unsigned FIELD_W  = 8,
  parameter int unsigned MIN_MAX  = 59,
  parameter int unsigned SEC_MAX  = 59,
  parameter int unsigned SUB_MAX  = 9
) (
  input  logic                   sclk,
  input  logic                   nrst,
  input  logic                   run,
  input  logic                   dir,
  input  logic                   wrap_en,
  input  logic                   clear,
  input  logic                   load,
  input  logic [3*FIELD_W-1:0]   load_val,
`ifdef MSS_UPDOWN_TIMER_LAP_EN
  input  logic                   lap,
  output logic [3*FIELD_W-1:0]   lap_time,
  output logic                   lap_valid,
`endif
  output logic [FIELD_W-1:0]     min,
  output logic [FIELD_W-1:0]     sec,
  output logic [FIELD_W-1:0]     sub,
  output logic [3*FIELD_W-1:0]   all_time,
  output logic                   tick,
  output logic                   done,
  output logic                   zero
);

  localparam int unsigned        PW       = $clog2(TICK_DIV);
  localparam logic [PW-1:0]      PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [FIELD_W-1:0] MIN_M    = FIELD_W'(MIN_MAX);
  localparam logic [FIELD_W-1:0] SEC_M    = FIELD_W'(SEC_MAX);
  localparam logic [FIELD_W-1:0] SUB_M    = FIELD_W'(SUB_MAX);

  logic [PW-1:0]      pre_q;
  logic               pre_wrap;
  logic               at_max;
  logic               at_term;
  logic               step;
  logic               next_term;
  logic [FIELD_W-1:0] min_n, sec_n, sub_n;

  function automatic logic [FIELD_W-1:0] clamp(input logic [FIELD_W-1:0] v,
                                               input logic [FIELD_W-1:0] m);
    return (v > m) ? m : v;
  endfunction

  assign pre_wrap = run && (pre_q == PRE_LAST);
  assign at_max   = (min == MIN_M) && (sec == SEC_M) && (sub == SUB_M);
  assign zero     = (min == '0) && (sec == '0) && (sub == '0);
  assign at_term  = dir ? at_max : zero;
  // Saturating mode swallows the step at the terminal value; the prescaler keeps going.
  assign step     = pre_wrap && (wrap_en || !at_term);
  assign all_time = {min, sec, sub};

  // Carry/borrow chain; wrapping past the terminal falls out naturally.
  always_comb begin
    min_n = min;
    sec_n = sec;
    sub_n = sub;
    if (dir) begin
      if (sub == SUB_M) begin
        sub_n = '0;
        if (sec == SEC_M) begin
          sec_n = '0;
          min_n = (min == MIN_M) ? '0 : min + 1'b1;
        end else begin
          sec_n = sec + 1'b1;
        end
      end else begin
        sub_n = sub + 1'b1;
      end
    end else begin
      if (sub == '0) begin
        sub_n = SUB_M;
        if (sec == '0) begin
          sec_n = SEC_M;
          min_n = (min == '0) ? MIN_M : min - 1'b1;
        end else begin
          sec_n = sec - 1'b1;
        end
      end else begin
        sub_n = sub - 1'b1;
      end
    end
  end

  assign next_term = dir ? ((min_n == MIN_M) && (sec_n == SEC_M) && (sub_n == SUB_M))
                         : ((min_n == '0) && (sec_n == '0) && (sub_n == '0));

  always_ff @(posedge sclk or negedge nrst) begin
    if (!nrst) begin
      pre_q <= '0;
      min   <= '0;
      sec   <= '0;
      sub   <= '0;
      tick  <= 1'b0;
      done  <= 1'b0;
    end else begin
      tick <= 1'b0;
      done <= 1'b0;
      if (clear) begin
        pre_q <= '0;
        min   <= '0;
        sec   <= '0;
        sub   <= '0;
      end else if (load) begin
        pre_q <= '0;
        min   <= clamp(load_val[3*FIELD_W-1:2*FIELD_W], MIN_M);
        sec   <= clamp(load_val[2*FIELD_W-1:FIELD_W], SEC_M);
        sub   <= clamp(load_val[FIELD_W-1:0], SUB_M);
      end else begin
        // Prescaler holds while paused so a partial tick survives a pause.
        if (run) begin
          pre_q <= (pre_q == PRE_LAST) ? '0 : pre_q + 1'b1;
        end
        if (step) begin
          min  <= min_n;
          sec  <= sec_n;
          sub  <= sub_n;
          tick <= 1'b1;
          done <= next_term;
        end
      end
    end
  end

`ifdef MSS_UPDOWN_TIMER_LAP_EN
  // Captures the pre-step fields when a step coincides with the lap pulse.
  always_ff @(posedge sclk or negedge nrst) begin
    if (!nrst) begin
      lap_time  <= '0;
      lap_valid <= 1'b0;
    end else begin
      lap_valid <= 1'b0;
      if (lap && !clear && !load) begin
        lap_time  <= {min, sec, sub};
        lap_valid <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mss_updown_timer.sv
// Purpose : directed self-checking bench for mss_updown_timer (TICK_DIV=4, 2:3:2 maxima).
// Latency : inputs driven and outputs sampled 1 ns after each rising sclk edge.
// Backpress: n/a.

module tb_mss_updown_timer;

  logic        sclk;
  logic        nrst;
  logic        run, dir, wrap_en, clear, load;
  logic [23:0] load_val;
  logic [7:0]  min, sec, sub;
  logic [23:0] all_time;
  logic        tick, done, zero;
`ifdef MSS_UPDOWN_TIMER_LAP_EN
  logic        lap;
  logic [23:0] lap_time;
  logic        lap_valid;
`endif

  int n_chk = 0;
  int n_err = 0;

  mss_updown_timer #(
    .TICK_DIV(4), .FIELD_W(8), .MIN_MAX(2), .SEC_MAX(3), .SUB_MAX(2)
  ) dut (
    .sclk(sclk), .nrst(nrst), .run(run), .dir(dir), .wrap_en(wrap_en),
    .clear(clear), .load(load), .load_val(load_val),
`ifdef MSS_UPDOWN_TIMER_LAP_EN
    .lap(lap), .lap_time(lap_time), .lap_valid(lap_valid),
`endif
    .min(min), .sec(sec), .sub(sub), .all_time(all_time),
    .tick(tick), .done(done), .zero(zero)
  );

  initial begin
    sclk = 1'b0;
    forever #5 sclk = ~sclk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge sclk);
      #1;
    end
  endtask

  function automatic logic [23:0] mss(input int m, input int s, input int u);
    return {m[7:0], s[7:0], u[7:0]};
  endfunction

  initial begin
    nrst = 1'b1; run = 1'b0; dir = 1'b0; wrap_en = 1'b0;
    clear = 1'b0; load = 1'b0; load_val = '0;
`ifdef MSS_UPDOWN_TIMER_LAP_EN
    lap = 1'b0;
`endif
    #2 nrst = 1'b0;
    #2;
    check("rst_time", all_time, 0);
    check("rst_zero", zero, 1);
    check("rst_tick", tick, 0);
    check("rst_done", done, 0);

    // Count up through the full range and wrap once.
    @(posedge sclk);
    #1;
    nrst = 1'b1; run = 1'b1; dir = 1'b1; wrap_en = 1'b1;
    for (int i = 1; i <= 36; i++) begin
      for (int k = 0; k < 3; k++) begin
        cyc(1);
        check("up_idle_tick", tick, 0);
      end
      cyc(1);
      check("up_val", all_time, mss((i % 36) / 12, ((i % 36) / 3) % 4, i % 3));
      check("up_tick", tick, 1);
      check("up_done", done, (i == 35) ? 1 : 0);
    end

    // Load 0:0:1, count down and saturate at zero.
    load_val = mss(0, 0, 1); dir = 1'b0; wrap_en = 1'b0; load = 1'b1;
    cyc(1);
    load = 1'b0;
    check("ld_val", all_time, mss(0, 0, 1));
    check("ld_tick", tick, 0);
    check("ld_zero", zero, 0);
    cyc(3);
    check("dn_pre_tick", tick, 0);
    cyc(1);
    check("dn_val", all_time, 0);
    check("dn_tick", tick, 1);
    check("dn_done", done, 1);
    check("dn_zero", zero, 1);
    for (int k = 0; k < 24; k++) begin
      cyc(1);
      check("sat_tick", tick, 0);
      check("sat_done", done, 0);
      check("sat_val", all_time, 0);
    end

    // Down wrap from zero lands on the up terminal: tick, no done.
    wrap_en = 1'b1;
    cyc(4);
    check("dnwrap_val", all_time, mss(2, 3, 2));
    check("dnwrap_tick", tick, 1);
    check("dnwrap_done", done, 0);

    // Up direction at 2:3:2 without wrap holds.
    dir = 1'b1; wrap_en = 1'b0;
    for (int k = 0; k < 8; k++) begin
      cyc(1);
      check("upsat_tick", tick, 0);
      check("upsat_val", all_time, mss(2, 3, 2));
    end

    // Clamped load then one down step.
    load_val = mss(9, 9, 9); dir = 1'b0; load = 1'b1;
    cyc(1);
    load = 1'b0;
    check("clamp_val", all_time, mss(2, 3, 2));
    cyc(4);
    check("clamp_step", all_time, mss(2, 3, 1));
    check("clamp_tick", tick, 1);
    check("clamp_done", done, 0);

    // Pause keeps the partial prescaler count.
    cyc(2);
    run = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cyc(1);
      check("pause_tick", tick, 0);
      check("pause_val", all_time, mss(2, 3, 1));
    end
    run = 1'b1;
    cyc(1);
    check("resume1_tick", tick, 0);
    cyc(1);
    check("resume2_tick", tick, 1);
    check("resume2_val", all_time, mss(2, 3, 0));

    // clear beats load in the same cycle.
    load_val = mss(1, 1, 1); clear = 1'b1; load = 1'b1;
    cyc(1);
    clear = 1'b0; load = 1'b0;
    check("clr_val", all_time, 0);
    check("clr_zero", zero, 1);
    check("clr_tick", tick, 0);

    // Count up to 0:1:0, lapping on that step.
    dir = 1'b1; wrap_en = 1'b1;
    cyc(11);
    check("lap_pre_val", all_time, mss(0, 0, 2));
`ifdef MSS_UPDOWN_TIMER_LAP_EN
    lap = 1'b1;
`endif
    cyc(1);
`ifdef MSS_UPDOWN_TIMER_LAP_EN
    lap = 1'b0;
    check("lap_time", lap_time, mss(0, 0, 2));
    check("lap_valid", lap_valid, 1);
`endif
    check("step010_val", all_time, mss(0, 1, 0));
    check("step010_tick", tick, 1);
    cyc(1);
`ifdef MSS_UPDOWN_TIMER_LAP_EN
    check("lap_valid_end", lap_valid, 0);
    check("lap_time_hold", lap_time, mss(0, 0, 2));
`endif

    // Asynchronous reset mid-count, then restart from a zero prescaler.
    #3 nrst = 1'b0;
    #1;
    check("arst_val", all_time, 0);
    check("arst_zero", zero, 1);
`ifdef MSS_UPDOWN_TIMER_LAP_EN
    check("arst_lap", lap_time, 0);
`endif
    #1 nrst = 1'b1;
    cyc(3);
    check("arst_hold_val", all_time, 0);
    check("arst_hold_tick", tick, 0);
    cyc(1);
    check("arst_step_val", all_time, mss(0, 0, 1));
    check("arst_step_tick", tick, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/mss_updown_timer.md
# mss_updown_timer

Parametrised min:sec:sub-second timer core that counts up or down at a fixed tick rate, with run/pause, load, clear, wrap/saturate terminal behaviour and a terminal-count pulse. It sits between the key/mode controller and the display/formatting logic. It serves both stopwatch and countdown modes from one instance.

## Interface
Parameters:
- TICK_DIV, 5_000_000, sclk cycles per sub-second step (100 ms at 50 MHz); must be ≥ 2
- FIELD_W, 8, width of each time field
- MIN_MAX, 59, maximum minute value
- SEC_MAX, 59, maximum second value
- SUB_MAX, 9, maximum sub-second value; each *_MAX must be < 2^FIELD_W

Ports:
- sclk  in  1  clock
- nrst  in  1  reset, asynchronous, active-low
- run  in  1  1 = counting, 0 = paused
- dir  in  1  1 = count up, 0 = count down
- wrap_en  in  1  1 = wrap at terminal value, 0 = stop at terminal value
- clear  in  1  single-cycle pulse, all fields and prescaler to 0
- load  in  1  single-cycle pulse, fields take load_val
- load_val  in  3*FIELD_W  {min, sec, sub}
- min, sec, sub  out  FIELD_W each  current time fields
- all_time  out  3*FIELD_W  {min, sec, sub}
- tick  out  1  one-cycle pulse, high in the cycle the fields show a newly stepped value
- done  out  1  one-cycle pulse, high in the cycle the fields first show the terminal value
- zero  out  1  level, high while min = sec = sub = 0

## Operation
- Reset: min, sec, sub, prescaler = 0; tick = done = 0; zero = 1.
- Priority per cycle: clear > load > step > hold. Each is independent of run.
- clear: fields = 0 and prescaler = 0. No tick, no done.
- load: each field = its load_val slice, clamped to its *_MAX if larger. Prescaler = 0. No tick, no done.
- Prescaler advances only while run = 1. It counts 0..TICK_DIV-1 and wraps to 0. A step occurs on the edge where it wraps.
- While run = 0, the prescaler holds its value, so a pause does not lose the partial tick.
- Up step: sub + 1. At SUB_MAX, sub → 0 and sec carries. At SEC_MAX, sec → 0 and min carries. At MIN_MAX, min → 0.
- Down step: sub − 1. At 0, sub → SUB_MAX and sec borrows. At 0, sec → SEC_MAX and min borrows. At 0, min → MIN_MAX.
- Terminal value: up = MIN_MAX:SEC_MAX:SUB_MAX; down = 0:0:0.
- wrap_en = 0 and fields already at the terminal value for the current dir: the step is suppressed. Fields hold, no tick, no done; the prescaler keeps running.
- wrap_en = 1 and fields at the terminal value: the step wraps to the opposite terminal value. tick fires; done does not.
- done fires whenever a step (not a load or clear) lands on the terminal value for the current dir, regardless of wrap_en.
- A dir change takes effect at the next step. The prescaler is not reset.

## Timing
- All outputs are registered. tick and done are asserted in the same cycle as the updated field values. zero is decoded from the field registers.
- With run held at 1 starting from prescaler = 0, the first step is visible TICK_DIV cycles later. Subsequent steps are spaced exactly TICK_DIV cycles apart.
- load or clear in cycle N: the new value is visible in cycle N+1, and the next step comes TICK_DIV running cycles after N.
- load coinciding with a prescaler wrap: load wins and no step is taken.
- nrst asserted mid-count: all state clears immediately (asynchronously). Counting resumes from 0:0:0 with the prescaler at 0.

## Configuration
- MSS_UPDOWN_TIMER_LAP_EN defined:
  - adds port lap (in, 1, single-cycle pulse);
  - adds port lap_time (out, 3*FIELD_W, reset 0);
  - adds port lap_valid (out, 1, one-cycle pulse).
- On a lap pulse in cycle N, lap_time takes the field values present in cycle N (the pre-step value if a step coincides), and lap_valid is high in cycle N+1.
- lap is ignored in a cycle where clear or load is asserted.
- MSS_UPDOWN_TIMER_LAP_EN undefined: the three lap ports and their registers are absent; all other behaviour is identical.

## Test plan
- Bench parameters: TICK_DIV = 4, MIN_MAX = 2, SEC_MAX = 3, SUB_MAX = 2.
- Reset, then run = 1, dir = 1, wrap_en = 1 → fields 0:0:1 after 4 cycles and 0:1:0 after 12, with one tick per step. At 2:3:2 done pulses once. The next step gives 0:0:0 with tick and no done.
- load_val = 0:0:1, dir = 0, wrap_en = 0, run = 1 → 0:0:0 after 4 cycles with done and tick high and zero = 1. Fields then hold 0:0:0 for 20+ cycles with no further tick or done.
- load_val = 9:9:9 → fields clamp to 2:3:2. Counting down from there, the first step gives 2:3:1.
- Pause: run = 1 for 2 cycles, 0 for 10 cycles, then 1 → the first step appears after 2 more running cycles. clear together with load in the same cycle → 0:0:0.
- With MSS_UPDOWN_TIMER_LAP_EN, pulse lap in the cycle of the 0:0:2 → 0:1:0 step → lap_time = 0:0:2 and lap_valid is high for one cycle. Assert nrst mid-count → lap_time, fields and prescaler all read 0 immediately.
